// File: rtl/mux_pkg.sv
// Purpose : shared constants and types for the 4-channel, 2-bit mux.
// Contents: DATA_W, NUM_CH, SEL_W widths; data_t and sel_t typedefs.
package mux_pkg;

    localparam int unsigned DATA_W = 2;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [SEL_W-1:0]  sel_t;

endpackage : mux_pkg

// File: rtl/mux_bit_sel.sv
// Purpose : 1-bit, 4:1 combinational selector; one instance per data bit.
// Ports   : sel_i  - channel select (0..3)
//           ch_i   - one bit from each channel, ch_i[n] = channel n
//           y_o    - the selected bit (combinational)
module mux_bit_sel
    import mux_pkg::*;
(
    input  logic [SEL_W-1:0]  sel_i,
    input  logic [NUM_CH-1:0] ch_i,
    output logic              y_o
);

    // Pick channel sel_i's bit.
    always_comb begin
        y_o = 1'b0;
        case (sel_i)
            2'd0:    y_o = ch_i[0];
            2'd1:    y_o = ch_i[1];
            2'd2:    y_o = ch_i[2];
            2'd3:    y_o = ch_i[3];
            default: y_o = 1'b0;
        endcase
    end

endmodule : mux_bit_sel

// File: rtl/mux.sv
// Purpose : 4-channel, 2-bit multiplexer with a registered output.
// Ports   : clk_i, rst_i (synchronous, active high)
//           direction_1_i/direction_0_i - select MSB/LSB
//           dataN_k_i - channel N (0..3), bit k (0..1)
//           data_k_o  - selected word, bit k
// Config  : MUX_COMB_OUT_EN - when defined, the output register is removed
//           and the outputs follow the selection combinationally; clk_i and
//           rst_i are then ignored. Default build registers with 1-cycle
//           latency and a synchronous clear.
module mux
    import mux_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic direction_0_i,
    input  logic direction_1_i,
    input  logic data0_0_i,
    input  logic data0_1_i,
    input  logic data1_0_i,
    input  logic data1_1_i,
    input  logic data2_0_i,
    input  logic data2_1_i,
    input  logic data3_0_i,
    input  logic data3_1_i,
    output logic data_0_o,
    output logic data_1_o
);

    sel_t                sel_c;
    logic [NUM_CH-1:0]   ch_bits_c [DATA_W];
    data_t               sel_data_c;

    assign sel_c = {direction_1_i, direction_0_i};

    // Regroup the flat ports per bit position: ch_bits_c[k][n] = channel n, bit k.
    assign ch_bits_c[0] = {data3_0_i, data2_0_i, data1_0_i, data0_0_i};
    assign ch_bits_c[1] = {data3_1_i, data2_1_i, data1_1_i, data0_1_i};

    // One bit selector per data bit.
    for (genvar k = 0; k < DATA_W; k++) begin : g_bit
        mux_bit_sel u_bit_sel (
            .sel_i (sel_c),
            .ch_i  (ch_bits_c[k]),
            .y_o   (sel_data_c[k])
        );
    end

`ifdef MUX_COMB_OUT_EN

    // Clock and reset have no function in this build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;

    assign data_0_o = sel_data_c[0];
    assign data_1_o = sel_data_c[1];

`else

    data_t data_d;
    data_t data_q;

    assign data_d = sel_data_c;

    // Output register; reset overrides the pending selection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= DATA_W'(0);
        end else begin
            data_q <= data_d;
        end
    end

    assign data_0_o = data_q[0];
    assign data_1_o = data_q[1];

`endif

endmodule : mux

// File: tb/tb_mux.sv
// Purpose : self-checking bench for mux. Reference model: the output word is
//           the selected channel's word (zero under reset), one clock later in
//           the default build, immediately with MUX_COMB_OUT_EN.
module tb_mux;

    logic       clk;
    logic       rst;
    logic [1:0] sel;
    logic [1:0] ch [4];
    logic       out0;
    logic       out1;
    logic [1:0] out_w;

    int checks = 0;
    int errors = 0;

    assign out_w = {out1, out0};

    mux dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .direction_0_i (sel[0]),
        .direction_1_i (sel[1]),
        .data0_0_i     (ch[0][0]),
        .data0_1_i     (ch[0][1]),
        .data1_0_i     (ch[1][0]),
        .data1_1_i     (ch[1][1]),
        .data2_0_i     (ch[2][0]),
        .data2_1_i     (ch[2][1]),
        .data3_0_i     (ch[3][0]),
        .data3_1_i     (ch[3][1]),
        .data_0_o      (out0),
        .data_1_o      (out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: expected word for the current inputs.
    function automatic logic [1:0] model(input logic r, input logic [1:0] s,
                                         input logic [1:0] c0, input logic [1:0] c1,
                                         input logic [1:0] c2, input logic [1:0] c3);
        logic [1:0] words [4];
        words[0] = c0; words[1] = c1; words[2] = c2; words[3] = c3;
        if (r) return 2'b00;
        return words[int'(s)];
    endfunction

    // Advance one edge and settle; inputs are driven after this point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifndef MUX_COMB_OUT_EN

    task automatic test_reset();
        for (int i = 0; i < 4; i++) ch[i] = 2'b11;
        sel = 2'b11;
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (out_w !== 2'b00) begin
                errors++;
                $display("FAIL reset_hold cyc%0d got %b want 00", c, out_w);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (out_w !== 2'b11) begin
            errors++;
            $display("FAIL reset_release got %b want 11", out_w);
        end
    endtask

    task automatic test_sweep();
        logic [1:0] exp;
        for (int i = 0; i < 4; i++) ch[i] = 2'(i);
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            exp = model(rst, sel, ch[0], ch[1], ch[2], ch[3]);
            tick();
            checks++;
            if (out_w !== exp) begin
                errors++;
                $display("FAIL sweep sel%0d got %b want %b", s, out_w, exp);
            end
        end
    endtask

    task automatic test_isolation();
        sel   = 2'b10;
        ch[2] = 2'b01;
        for (int c = 0; c < 8; c++) begin
            ch[0] = ~ch[0];
            ch[1] = 2'($urandom_range(0, 3));
            ch[3] = 2'(c);
            tick();
            checks++;
            if (out_w !== 2'b01) begin
                errors++;
                $display("FAIL isolation cyc%0d got %b want 01", c, out_w);
            end
        end
    endtask

    task automatic test_simultaneous();
        sel   = 2'b01;
        ch[1] = 2'b11;
        ch[3] = 2'b00;
        tick();
        checks++;
        if (out_w !== 2'b11) begin
            errors++;
            $display("FAIL simul_before got %b want 11", out_w);
        end
        sel   = 2'b11;
        ch[3] = 2'b10;
        tick();
        checks++;
        if (out_w !== 2'b10) begin
            errors++;
            $display("FAIL simul_after got %b want 10", out_w);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] exp;
        sel   = 2'b00;
        ch[0] = 2'b10;
        rst   = 1'b1;
        tick();
        checks++;
        if (out_w !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid got %b want 00", out_w);
        end
        rst   = 1'b0;
        ch[0] = 2'b01;
        exp   = model(rst, sel, ch[0], ch[1], ch[2], ch[3]);
        tick();
        checks++;
        if (out_w !== exp) begin
            errors++;
            $display("FAIL reset_mid_resume got %b want %b", out_w, exp);
        end
    endtask

    task automatic test_random();
        logic [1:0] w;
        for (int n = 0; n < 100; n++) begin
            sel = 2'($urandom_range(0, 3));
            w   = 2'($urandom_range(0, 3));
            for (int i = 0; i < 4; i++) ch[i] = 2'($urandom_range(0, 3));
            ch[int'(sel)] = w;
            tick();
            checks++;
            if (out_w !== w) begin
                errors++;
                $display("FAIL random it%0d sel%0d got %b want %b", n, sel, out_w, w);
                break;
            end
        end
    endtask

`else

    task automatic test_comb_sweep();
        for (int i = 0; i < 4; i++) ch[i] = 2'(i);
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            checks++;
            if (out_w !== 2'(s)) begin
                errors++;
                $display("FAIL comb_sweep sel%0d got %b want %b", s, out_w, 2'(s));
            end
        end
    endtask

    task automatic test_comb_random();
        logic [1:0] exp;
        for (int n = 0; n < 20; n++) begin
            sel = 2'($urandom_range(0, 3));
            for (int i = 0; i < 4; i++) ch[i] = 2'($urandom_range(0, 3));
            rst = 1'($urandom_range(0, 1));
            exp = model(1'b0, sel, ch[0], ch[1], ch[2], ch[3]);
            #1;
            checks++;
            if (out_w !== exp) begin
                errors++;
                $display("FAIL comb_random it%0d got %b want %b", n, out_w, exp);
            end
        end
    endtask

`endif

    initial begin
        rst = 1'b0;
        sel = 2'b00;
        for (int i = 0; i < 4; i++) ch[i] = 2'b00;
`ifndef MUX_COMB_OUT_EN
        test_reset();
        test_sweep();
        test_isolation();
        test_simultaneous();
        test_reset_mid();
        test_random();
`else
        test_comb_sweep();
        test_comb_random();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mux
